// File: rtl/cdec_trace_dumper.sv
// Trace dumper for the CDEC core: records architectural state on each fetch and streams it as bytes.
// On halt it appends a marker byte and then a dump of RAM read through a spare read port.
module cdec_trace_dumper #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] MARKER     = 8'hA5,
    parameter int         DUMP_WORDS = 256
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       iFetch,
    input  logic [7:0] iRegPC,
    input  logic [7:0] iRegA,
    input  logic [7:0] iRegB,
    input  logic [7:0] iRegC,
    input  logic [2:0] iFlags,
    output logic [7:0] oMemAddr,
    output logic       oMemRe,
    input  logic [7:0] iMemData,
    output logic [7:0] oTxData,
    output logic       oTxValid,
    input  logic       iTxReady,
    output logic       oHalt,
    output logic       oOverflow,
    output logic       oDone
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [7:0]    LAST_ADDR = 8'(DUMP_WORDS - 1);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SEND = 3'd1;
    localparam logic [2:0] ST_MARK = 3'd2;
    localparam logic [2:0] ST_RD   = 3'd3;
    localparam logic [2:0] ST_XMIT = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    logic [39:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [7:0]    pre_pc_reg;
    logic          halt_reg, ovf_reg;
    logic [2:0]    state_reg, state_next;
    logic [2:0]    idx_reg, idx_next;
    logic [7:0]    addr_reg, addr_next;
    logic [7:0]    tx_data_reg, tx_data_next;

    logic        fetch_live, pc_repeat, push_req, push_ok, pop, full, tx_xfer;
    logic [39:0] rec_in, head_rec;
    logic [7:0]  head_byte [8];

    assign fetch_live = iFetch & ~halt_reg;
    assign pc_repeat  = (iRegPC == pre_pc_reg);
    assign push_req   = fetch_live & ~pc_repeat;
    assign full       = (count_reg == DEPTH_CNT);
    assign tx_xfer    = oTxValid & iTxReady;
    assign pop        = (state_reg == ST_SEND) && (idx_reg == 3'd4) && tx_xfer;
    // A full FIFO still accepts a record when the head leaves on the same edge.
    assign push_ok    = push_req & (~full | pop);
    assign rec_in     = {iRegPC, iRegA, iRegB, iRegC, 5'b0, iFlags};
    assign head_rec   = fifo_mem[rd_ptr_reg];

    for (genvar gi = 0; gi < 8; gi++) begin : g_head_byte
        if (gi < 5) begin : g_field
            assign head_byte[gi] = head_rec[39 - 8*gi -: 8];
        end else begin : g_pad
            assign head_byte[gi] = 8'h00;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset && push_ok) begin
            fifo_mem[wr_ptr_reg] <= rec_in;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            pre_pc_reg  <= 8'hFF;
            halt_reg    <= 1'b0;
            ovf_reg     <= 1'b0;
            state_reg   <= ST_IDLE;
            idx_reg     <= 3'd0;
            addr_reg    <= 8'h00;
            tx_data_reg <= 8'h00;
        end else begin
            if (fetch_live && pc_repeat) begin
                halt_reg <= 1'b1;
            end
            if (push_req) begin
                pre_pc_reg <= iRegPC;
            end
            if (push_req && !push_ok) begin
                ovf_reg <= 1'b1;
            end
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: ;
            endcase
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            addr_reg    <= addr_next;
            tx_data_reg <= tx_data_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        addr_next    = addr_reg;
        tx_data_next = tx_data_reg;
        case (state_reg)
            ST_IDLE: begin
                // Pending records always drain before the marker.
                if (count_reg != '0) begin
                    state_next = ST_SEND;
                    idx_next   = 3'd0;
                end else if (halt_reg) begin
                    state_next = ST_MARK;
                end
            end
            ST_SEND: begin
                if (tx_xfer) begin
                    if (idx_reg == 3'd4) begin
                        state_next = ST_IDLE;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end
            end
            ST_MARK: begin
                if (tx_xfer) begin
                    addr_next  = 8'h00;
                    state_next = ST_RD;
                end
            end
            ST_RD: begin
                tx_data_next = iMemData;
                state_next   = ST_XMIT;
            end
            ST_XMIT: begin
                if (tx_xfer) begin
                    if (addr_reg == LAST_ADDR) begin
                        state_next = ST_DONE;
                    end else begin
                        addr_next  = addr_reg + 8'd1;
                        state_next = ST_RD;
                    end
                end
            end
            ST_DONE: state_next = ST_DONE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        oTxData = 8'h00;
        case (state_reg)
            ST_SEND: oTxData = head_byte[idx_reg];
            ST_MARK: oTxData = MARKER;
            ST_XMIT: oTxData = tx_data_reg;
            default: oTxData = 8'h00;
        endcase
    end

    assign oTxValid  = (state_reg == ST_SEND) || (state_reg == ST_MARK) || (state_reg == ST_XMIT);
    assign oMemRe    = (state_reg == ST_RD);
    assign oMemAddr  = addr_reg;
    assign oHalt     = halt_reg;
    assign oOverflow = ovf_reg;
    assign oDone     = (state_reg == ST_DONE);
endmodule

// File: tb/tb_cdec_trace_dumper.sv
// Bench for cdec_trace_dumper: an expected-byte scoreboard built from fetch events,
// checked every cycle, plus directed scenarios with literal expectations.
module tb_cdec_trace_dumper;
    localparam int         DEPTH = 4;
    localparam logic [7:0] MARK  = 8'hA5;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       iFetch = 1'b0;
    logic [7:0] iRegPC = 8'h00, iRegA = 8'h00, iRegB = 8'h00, iRegC = 8'h00;
    logic [2:0] iFlags = 3'b000;
    logic [7:0] oMemAddr;
    logic       oMemRe;
    logic [7:0] iMemData;
    logic [7:0] oTxData;
    logic       oTxValid;
    logic       iTxReady;
    logic       oHalt, oOverflow, oDone;

    logic       ready_lvl = 1'b1;
    logic       tog_en = 1'b0;
    logic       tog = 1'b0;
    logic [7:0] mem_q = 8'h00;
    logic [7:0] ram [256];

    always #5 Clk = ~Clk;

    cdec_trace_dumper #(.FIFO_DEPTH(DEPTH), .MARKER(MARK), .DUMP_WORDS(256)) dut (
        .Clk(Clk), .Reset(Reset), .iFetch(iFetch), .iRegPC(iRegPC), .iRegA(iRegA),
        .iRegB(iRegB), .iRegC(iRegC), .iFlags(iFlags), .oMemAddr(oMemAddr), .oMemRe(oMemRe),
        .iMemData(iMemData), .oTxData(oTxData), .oTxValid(oTxValid), .iTxReady(iTxReady),
        .oHalt(oHalt), .oOverflow(oOverflow), .oDone(oDone)
    );

    // RAM read port: data follows the address within half a cycle.
    always @(negedge Clk) mem_q <= ram[oMemAddr];
    assign iMemData = mem_q;
    assign iTxReady = tog_en ? tog : ready_lvl;
    always @(posedge Clk) begin
        #1;
        tog = ~tog;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected byte stream, written at posedge, consumed at negedge.
    typedef struct packed {
        logic [7:0] d;
        logic       rec_end;
        logic       dump_end;
        logic       is_dump;
    } exp_t;
    exp_t exp_mem [4096];
    int   exp_wr = 0;
    int   exp_rd = 0;

    logic [7:0] m_pre = 8'hFF;
    logic       m_halt = 1'b0, m_ovf = 1'b0, m_done = 1'b0;
    int         m_inflight = 0;
    int         pops_seen = 0, pops_used = 0;
    logic       done_seen = 1'b0;
    int         dump_sent = 0;

    logic [7:0] log_mem [4096];
    int         log_n = 0;

    task automatic push_exp(input logic [7:0] d, input logic rec_end, input logic dump_end,
                            input logic is_dump);
        exp_mem[exp_wr % 4096] = '{d: d, rec_end: rec_end, dump_end: dump_end, is_dump: is_dump};
        exp_wr++;
    endtask

    // Model: decides per fetch whether a record is queued, dropped, or the core halted.
    always @(posedge Clk) begin
        logic pop_now;
        if (Reset) begin
            m_pre = 8'hFF; m_halt = 1'b0; m_ovf = 1'b0; m_done = 1'b0;
            m_inflight = 0; pops_used = pops_seen; exp_wr = exp_rd;
        end else begin
            pop_now   = (pops_used != pops_seen);
            pops_used = pops_seen;
            m_done    = done_seen;
            if (iFetch && !m_halt) begin
                if (iRegPC == m_pre) begin
                    m_halt = 1'b1;
                    push_exp(MARK, 1'b0, 1'b0, 1'b0);
                    for (int i = 0; i < 256; i++) push_exp(ram[i], 1'b0, (i == 255), 1'b1);
                end else begin
                    m_pre = iRegPC;
                    if (m_inflight < DEPTH || pop_now) begin
                        push_exp(iRegPC, 1'b0, 1'b0, 1'b0);
                        push_exp(iRegA, 1'b0, 1'b0, 1'b0);
                        push_exp(iRegB, 1'b0, 1'b0, 1'b0);
                        push_exp(iRegC, 1'b0, 1'b0, 1'b0);
                        push_exp({5'b0, iFlags}, 1'b1, 1'b0, 1'b0);
                        m_inflight++;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
            if (pop_now) m_inflight--;
        end
    end

    // Compare process: every cycle, outputs against the model.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    always @(negedge Clk) begin
        exp_t e;
        if (Reset) begin
            done_seen = 1'b0; dump_sent = 0; prev_stall = 1'b0;
        end else begin
            check("halt", oHalt, m_halt);
            check("overflow", oOverflow, m_ovf);
            check("done", oDone, m_done);
            if (oMemRe) begin
                check("rd_valid_low", oTxValid, 1'b0);
                check("rd_addr", oMemAddr, dump_sent[7:0]);
            end
            if (oDone) begin
                check("done_memre", oMemRe, 1'b0);
                check("done_valid", oTxValid, 1'b0);
            end
            if (prev_stall) begin
                check("stall_valid", oTxValid, 1'b1);
                check("stall_data", oTxData, prev_data);
            end
            if (oTxValid && iTxReady) begin
                if (exp_rd == exp_wr) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte actual=%02h required=none", oTxData);
                end else begin
                    e = exp_mem[exp_rd % 4096];
                    exp_rd++;
                    check("tx_byte", oTxData, e.d);
                    if (e.rec_end) pops_seen++;
                    if (e.is_dump) dump_sent++;
                    if (e.dump_end) done_seen = 1'b1;
                end
                log_mem[log_n % 4096] = oTxData;
                log_n++;
                $display("tx byte=%02h", oTxData);
            end
            prev_stall = oTxValid && !iTxReady;
            prev_data  = oTxData;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic fetch(input logic [7:0] pc, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [2:0] f);
        iFetch = 1'b1; iRegPC = pc; iRegA = a; iRegB = b; iRegC = c; iFlags = f;
        tick();
        iFetch = 1'b0;
        $display("fetch pc=%02h a=%02h b=%02h c=%02h flags=%03b", pc, a, b, c, f);
    endtask

    task automatic do_reset(input string tag);
        Reset = 1'b1;
        tick();
        check({tag, "_txdata"}, oTxData, 8'h00);
        check({tag, "_txvalid"}, oTxValid, 1'b0);
        check({tag, "_memaddr"}, oMemAddr, 8'h00);
        check({tag, "_memre"}, oMemRe, 1'b0);
        check({tag, "_halt"}, oHalt, 1'b0);
        check({tag, "_ovf"}, oOverflow, 1'b0);
        check({tag, "_done"}, oDone, 1'b0);
        Reset = 1'b0;
        tick();
        $display("reset %s", tag);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (!(exp_wr == exp_rd && !oTxValid) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL %s_timeout actual=%0d cycles required<%0d", name, n, budget);
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!oDone && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL %s_timeout actual=%0d cycles required<%0d", name, n, budget);
        end
    endtask

    task automatic check_log(input string name, input int base, input int idx, input logic [7:0] exp);
        check(name, log_mem[(base + idx) % 4096], exp);
    endtask

    initial begin
        int base;
        int bad;
        logic [7:0] seq3 [15];
        seq3 = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h05, 8'h01, 8'h11, 8'h22, 8'h33, 8'h05,
                 8'h02, 8'h11, 8'h22, 8'h33, 8'h05};
        for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'h5A;

        tick();
        do_reset("rst0");

        // Three records, sink always ready.
        base = log_n;
        fetch(8'h00, 8'h11, 8'h22, 8'h33, 3'b101);
        fetch(8'h01, 8'h11, 8'h22, 8'h33, 3'b101);
        fetch(8'h02, 8'h11, 8'h22, 8'h33, 3'b101);
        wait_idle("seq3", 200);
        check("seq3_count", log_n - base, 15);
        for (int i = 0; i < 15; i++) check_log("seq3_byte", base, i, seq3[i]);

        // Repeated PC halts; one record, marker, then full dump.
        base = log_n;
        fetch(8'h07, 8'h11, 8'h22, 8'h33, 3'b101);
        check("halt_after_first07", oHalt, 1'b0);
        fetch(8'h07, 8'h11, 8'h22, 8'h33, 3'b101);
        check("halt_after_second07", oHalt, 1'b1);
        wait_done("dump", 1500);
        check("dump_count", log_n - base, 262);
        check_log("dump_pc", base, 0, 8'h07);
        check_log("dump_marker", base, 5, 8'hA5);
        check_log("dump_first", base, 6, 8'h5A);
        check_log("dump_second", base, 7, 8'h5B);
        check_log("dump_last", base, 261, 8'hA5);
        check("dump_done", oDone, 1'b1);
        check("dump_memre_low", oMemRe, 1'b0);
        tick();
        check("dump_stays_done", oDone, 1'b1);

        // Overflow with a stalled sink.
        do_reset("rst1");
        ready_lvl = 1'b0;
        base = log_n;
        fetch(8'h10, 8'hA0, 8'hB0, 8'hC0, 3'b001);
        fetch(8'h11, 8'hA1, 8'hB1, 8'hC1, 3'b010);
        fetch(8'h12, 8'hA2, 8'hB2, 8'hC2, 3'b011);
        fetch(8'h13, 8'hA3, 8'hB3, 8'hC3, 3'b100);
        check("ovf_after4", oOverflow, 1'b0);
        fetch(8'h14, 8'hA4, 8'hB4, 8'hC4, 3'b110);
        check("ovf_after5", oOverflow, 1'b1);
        fetch(8'h15, 8'hA5, 8'hB5, 8'hC5, 3'b111);
        ready_lvl = 1'b1;
        wait_idle("ovf_drain", 200);
        check("ovf_count", log_n - base, 20);
        for (int r = 0; r < 4; r++) begin
            check_log("ovf_pc", base, 5*r, 8'h10 + 8'(r));
            check_log("ovf_a", base, 5*r + 1, 8'hA0 + 8'(r));
            check_log("ovf_flags", base, 5*r + 4, 8'(r + 1));
        end
        check("ovf_sticky", oOverflow, 1'b1);

        // Dump with a toggling sink.
        do_reset("rst2");
        tog_en = 1'b1;
        base = log_n;
        fetch(8'h33, 8'h44, 8'h55, 8'h66, 3'b010);
        fetch(8'h33, 8'h44, 8'h55, 8'h66, 3'b010);
        wait_done("tog_dump", 3000);
        tog_en = 1'b0;
        check("tog_count", log_n - base, 262);
        check_log("tog_marker", base, 5, 8'hA5);
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (log_mem[(base + 6 + i) % 4096] !== (8'(i) ^ 8'h5A)) bad++;
        check("tog_dump_seq_errors", bad, 0);

        // Reset in the middle of a dump, then halt straight from reset.
        do_reset("rst3");
        fetch(8'hFF, 8'h00, 8'h00, 8'h00, 3'b000);
        check("ff_halt_immediate", oHalt, 1'b1);
        begin
            int n = 0;
            while (!(oMemRe && oMemAddr == 8'h40) && n < 400) begin
                tick();
                n++;
            end
            check("mid_dump_reached", (oMemRe && oMemAddr == 8'h40), 1'b1);
        end
        do_reset("rst_mid");
        base = log_n;
        fetch(8'hFF, 8'h00, 8'h00, 8'h00, 3'b000);
        check("ff_halt_again", oHalt, 1'b1);
        wait_done("redump", 1500);
        check("redump_count", log_n - base, 257);
        check_log("redump_marker", base, 0, 8'hA5);
        check_log("redump_first", base, 1, 8'h5A);
        check_log("redump_addr40", base, 1 + 8'h40, 8'h40 ^ 8'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
